ac_control: RTL

AC_CONTROL -- requirements
Module: ac_control

---
 rtl/ac_pkg.sv | 24 ++
 rtl/ac_control.sv | 110 +++++++++++
 2 files changed

// File: rtl/ac_pkg.sv
// Shared opcode and state encodings for the accumulator CPU controller.
package ac_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_LDA = 3'b010,
    OP_STA = 3'b011,
    OP_JMP = 3'b100,
    OP_JZ  = 3'b101,
    OP_JC  = 3'b110,
    OP_HLT = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPER   = 3'd3,
    S_BRANCH = 3'd4,
    S_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/ac_control.sv
// Multi-cycle control FSM for the accumulator CPU: fetch, decode,
// operand access or branch, halt, plus a retired-instruction counter.
module ac_control
  import ac_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic             mem_ready_i,
  input  logic             branch_i,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic             addr_sel_o,
  output logic             ir_load_o,
  output logic             pc_inc_o,
  output logic             pc_load_o,
  output logic             ctrl_jmp_o,
  output logic             acc_load_o,
  output logic             flag_load_o,
  output logic             sub_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic is_sta;
  logic is_sub;
  logic is_alu;

  assign is_sta = (op_i == OP_STA);
  assign is_sub = (op_i == OP_SUB);
  assign is_alu = (op_i == OP_ADD) || is_sub;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if (op_i == OP_HLT)  state_d = S_HALT;
        else if (op_i[2])    state_d = S_BRANCH;
        else                 state_d = S_OPER;
      end
      S_OPER:   if (mem_ready_i) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   if (start_i) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // An instruction retires when it leaves OPER or BRANCH.
  always_comb begin
    retired_d = retired_q;
    if ((state_q == S_OPER && mem_ready_i) || state_q == S_BRANCH)
      retired_d = retired_q + CNT_W'(1);
  end

  always_comb begin
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    addr_sel_o  = 1'b0;
    ir_load_o   = 1'b0;
    pc_inc_o    = 1'b0;
    pc_load_o   = 1'b0;
    ctrl_jmp_o  = 1'b0;
    acc_load_o  = 1'b0;
    flag_load_o = 1'b0;
    sub_o       = 1'b0;
    halted_o    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_rd_o  = 1'b1;
        ir_load_o = mem_ready_i;
        pc_inc_o  = mem_ready_i;
      end
      S_OPER: begin
        addr_sel_o  = 1'b1;
        mem_rd_o    = !is_sta;
        mem_wr_o    = is_sta;
        acc_load_o  = mem_ready_i && !is_sta;
        flag_load_o = mem_ready_i && is_alu;
        sub_o       = is_sub;
      end
      S_BRANCH: begin
        ctrl_jmp_o = 1'b1;
        pc_load_o  = branch_i;
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

  assign retired_o = retired_q;

endmodule
